btn_reader: RTL and testbench

//  Input-side counterpart to the board LED drivers: samples N raw ZedBoard push buttons
//  (asynchronous, bouncing), synchronises and debounces each one, and emits a clean

---
 rtl/btn_reader_pkg.sv | 22 ++
 rtl/btn_reader_debounce_ch.sv | 129 ++++++++++++
 rtl/btn_reader.sv | 73 +++++++
 tb/tb_btn_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_reader_pkg.sv
// Shared types and helpers for the push-button reader.
package btn_reader_pkg;

   // Per-channel debounce state encoding.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRESS_DB = 3'd1,
      ST_HELD     = 3'd2,
      ST_RPT      = 3'd3,
      ST_REL_DB   = 3'd4
   } btn_state_e;

   // Largest of three cycle counts; sizes the per-channel counter check.
   function automatic int cyc_max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/btn_reader_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce/hold/repeat FSM and
// registered level and pulse outputs.
module btn_reader_debounce_ch
   import btn_reader_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int DEBOUNCE_CYC = 2_000_000,
   parameter int HOLD_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 25_000_000,
   parameter bit REPEAT_EN    = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic rel,
   output logic rpt
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             rpt_q, rpt_d;

   // Next-state, counter and pulse decode; the counter saturates so it can never wrap.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rpt_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync2_q) begin
               state_d = ST_PRESS_DB;
               cnt_d   = '0;
            end
         end
         ST_PRESS_DB: begin
            if (!sync2_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end
         end
         ST_HELD: begin
            if (!sync2_q) begin
               state_d = ST_REL_DB;
               cnt_d   = '0;
            end else if (REPEAT_EN && (cnt_q == HOLD_LAST)) begin
               state_d = ST_RPT;
               cnt_d   = '0;
               rpt_d   = 1'b1;
            end
         end
         ST_RPT: begin
            if (!sync2_q) begin
               state_d = ST_REL_DB;
               cnt_d   = '0;
            end else if (cnt_q == RPT_LAST) begin
               cnt_d   = '0;
               rpt_d   = 1'b1;
            end
         end
         ST_REL_DB: begin
            // A bounce back high returns to HELD and restarts the hold timer.
            if (sync2_q) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // State, synchroniser and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         rpt_q   <= rpt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;
   assign rel   = rel_q;
   assign rpt   = rpt_q;

endmodule

// File: rtl/btn_reader.sv
// N-channel push-button reader: one debounce channel per pin plus a
// registered "any activity" flag.
module btn_reader
   import btn_reader_pkg::*;
#(
   parameter int N_BTN        = 5,
   parameter int CNT_W        = 32,
   parameter int DEBOUNCE_CYC = 2_000_000,
   parameter int HOLD_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 25_000_000,
   parameter bit REPEAT_EN    = 1'b1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [N_BTN-1:0] BTN,
   output logic [N_BTN-1:0] BTN_LEVEL,
   output logic [N_BTN-1:0] BTN_PRESS,
   output logic [N_BTN-1:0] BTN_RELEASE,
   output logic [N_BTN-1:0] BTN_REPEAT,
   output logic             BTN_ANY
);

   localparam int MAX_CYC = cyc_max3(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);

   if ((DEBOUNCE_CYC < 1) || (HOLD_CYC < 1) || (REPEAT_CYC < 1)) begin : g_bad_cyc
      $error("btn_reader: DEBOUNCE_CYC, HOLD_CYC and REPEAT_CYC must all be >= 1");
   end

   if ((CNT_W < 1) || ((longint'(MAX_CYC) >> CNT_W) != 0)) begin : g_bad_cnt_w
      $error("btn_reader: CNT_W too narrow for the largest cycle count");
   end

   logic [N_BTN-1:0] press_w;
   logic [N_BTN-1:0] rpt_w;
   logic             any_q, any_d;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_reader_debounce_ch #(
         .CNT_W        (CNT_W),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC),
         .REPEAT_EN    (REPEAT_EN)
      ) u_ch (
         .clk     (CLK),
         .rst_n   (RST_N),
         .btn_raw (BTN[g]),
         .level   (BTN_LEVEL[g]),
         .press   (press_w[g]),
         .rel     (BTN_RELEASE[g]),
         .rpt     (rpt_w[g])
      );
   end

   // Any press or repeat on any channel, one cycle behind the channel pulses.
   always_comb begin
      any_d = |(press_w | rpt_w);
   end

   // Activity flag register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         any_q <= 1'b0;
      end else begin
         any_q <= any_d;
      end
   end

   assign BTN_PRESS  = press_w;
   assign BTN_REPEAT = rpt_w;
   assign BTN_ANY    = any_q;

endmodule

// File: tb/tb_btn_reader.sv
// Bench for btn_reader: two instances (repeat enabled / disabled) driven by
// the same pins, compared every cycle against a run-length reference model.
module tb_btn_reader;

   localparam int D = 4;
   localparam int H = 10;
   localparam int R = 5;

   logic       clk;
   logic       rst_n;
   logic [1:0] btn;

   logic [1:0] lvl0, prs0, rel0, rpt0;
   logic       any0;
   logic [1:0] lvl1, prs1, rel1, rpt1;
   logic       any1;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state, [instance][channel]
   bit   ms1   [2][2];
   bit   ms2   [2][2];
   int   run1  [2][2];
   int   run0  [2][2];
   int   since [2][2];
   bit   mlvl  [2][2];
   logic [1:0] e_lvl [2];
   logic [1:0] e_prs [2];
   logic [1:0] e_rel [2];
   logic [1:0] e_rpt [2];
   logic       e_any [2];

   btn_reader #(
      .N_BTN(2), .CNT_W(8), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .REPEAT_EN(1'b1)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .BTN(btn),
      .BTN_LEVEL(lvl0), .BTN_PRESS(prs0), .BTN_RELEASE(rel0), .BTN_REPEAT(rpt0), .BTN_ANY(any0)
   );

   btn_reader #(
      .N_BTN(2), .CNT_W(8), .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .REPEAT_EN(1'b0)
   ) dut_norpt (
      .CLK(clk), .RST_N(rst_n), .BTN(btn),
      .BTN_LEVEL(lvl1), .BTN_PRESS(prs1), .BTN_RELEASE(rel1), .BTN_REPEAT(rpt1), .BTN_ANY(any1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: a press is accepted after D+1 consecutive high samples of the
   // synchronised input, a release after D+1 consecutive low samples. While the
   // level is high, repeats fire H samples after the last high-run start and
   // every R samples after that.
   task automatic model_edge();
      logic s, p, r, q, any_n;
      for (int i = 0; i < 2; i++) begin
         any_n = |(e_prs[i] | e_rpt[i]);
         for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
               ms1[i][c] = 0; ms2[i][c] = 0; run1[i][c] = 0; run0[i][c] = 0;
               since[i][c] = 0; mlvl[i][c] = 0;
               e_lvl[i][c] = 0; e_prs[i][c] = 0; e_rel[i][c] = 0; e_rpt[i][c] = 0;
            end else begin
               s = ms2[i][c]; p = 0; r = 0; q = 0;
               if (!mlvl[i][c]) begin
                  if (s) begin
                     run1[i][c]++;
                     if (run1[i][c] == D + 1) begin
                        mlvl[i][c] = 1; p = 1; since[i][c] = 0; run0[i][c] = 0; run1[i][c] = 0;
                     end
                  end else begin
                     run1[i][c] = 0;
                  end
               end else begin
                  if (s) begin
                     if (run0[i][c] > 0) begin
                        run0[i][c] = 0; since[i][c] = 0;
                     end else begin
                        since[i][c]++;
                        if (i == 0 && since[i][c] >= H && ((since[i][c] - H) % R) == 0) q = 1;
                     end
                  end else begin
                     run0[i][c]++;
                     if (run0[i][c] == D + 1) begin
                        mlvl[i][c] = 0; r = 1; run0[i][c] = 0; run1[i][c] = 0;
                     end
                  end
               end
               ms2[i][c] = ms1[i][c];
               ms1[i][c] = btn[c];
               e_lvl[i][c] = mlvl[i][c];
               e_prs[i][c] = p;
               e_rel[i][c] = r;
               e_rpt[i][c] = q;
            end
         end
         e_any[i] = rst_n ? any_n : 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("u0_level",   32'(lvl0), 32'(e_lvl[0]));
      chk("u0_press",   32'(prs0), 32'(e_prs[0]));
      chk("u0_release", 32'(rel0), 32'(e_rel[0]));
      chk("u0_repeat",  32'(rpt0), 32'(e_rpt[0]));
      chk("u0_any",     32'(any0), 32'(e_any[0]));
      chk("u1_level",   32'(lvl1), 32'(e_lvl[1]));
      chk("u1_press",   32'(prs1), 32'(e_prs[1]));
      chk("u1_release", 32'(rel1), 32'(e_rel[1]));
      chk("u1_repeat",  32'(rpt1), 32'(e_rpt[1]));
      chk("u1_any",     32'(any1), 32'(e_any[1]));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      int first, rel_e, cnt_a, cnt_b, len;
      rst_n = 1'b0;
      btn   = 2'b00;
      for (int i = 0; i < 2; i++) begin
         e_lvl[i] = 0; e_prs[i] = 0; e_rel[i] = 0; e_rpt[i] = 0; e_any[i] = 0;
      end

      // 1: reset with both buttons pressed, then fresh press after release
      btn = 2'b11;
      run(3);
      chk("t1_rst_outputs", 32'({lvl0, prs0, rel0, rpt0, any0}), 32'd0);
      rst_n = 1'b1;
      first = -1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (first < 0 && prs0 == 2'b11) first = k;
      end
      chk("t1_press_edge", 32'(first), 32'd6);
      chk("t1_level", 32'(lvl0), 32'h3);
      btn = 2'b00;
      run(12);

      // 2: clean press / release on channel 0
      btn = 2'b01;
      first = -1; rel_e = -1;
      for (int k = 0; k < 20; k++) begin
         if (k == 8) btn = 2'b00;
         step();
         if (first < 0 && prs0[0]) first = k;
         if (rel_e < 0 && rel0[0]) rel_e = k;
      end
      chk("t2_press_edge", 32'(first), 32'd6);
      chk("t2_release_edge", 32'(rel_e), 32'd14);
      chk("t2_level", 32'(lvl0[0]), 32'd0);
      run(5);

      // 3: bounce pattern never settles long enough
      cnt_a = 0;
      for (int k = 0; k < 40; k++) begin
         btn[0] = ((k % 4) != 3);
         step();
         cnt_a += int'(prs0[0]) + int'(rel0[0]);
      end
      btn = 2'b00;
      run(8);
      chk("t3_bounce_pulses", 32'(cnt_a), 32'd0);

      // 4: hold channel 1 for 40 cycles
      btn = 2'b10;
      cnt_a = 0; first = -1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (rpt0[1]) cnt_a++;
         if (first < 0 && rpt0[1]) first = k;
      end
      chk("t4_repeat_count", 32'(cnt_a), 32'd5);
      chk("t4_first_repeat", 32'(first), 32'd16);
      btn = 2'b00;
      run(12);

      // 5: short low glitch while held pushes the first repeat out
      cnt_a = 0; first = -1;
      for (int k = 0; k < 44; k++) begin
         btn[0] = !(k == 12 || k == 13);
         step();
         cnt_a += int'(rel0[0]);
         if (first < 0 && rpt0[0]) first = k;
      end
      chk("t5_no_release", 32'(cnt_a), 32'd0);
      chk("t5_first_repeat", 32'(first), 32'd26);
      btn = 2'b00;
      run(12);

      // 6: reset in the middle of repeating; no-repeat instance held 60 cycles
      btn = 2'b11;
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 60; k++) begin
         rst_n = (k != 30);
         step();
         if (k == 30) chk("t6_rst_outputs", 32'({lvl0, prs0, rel0, rpt0, any0}), 32'd0);
         cnt_a += int'(|rel0);
         cnt_b += int'(|rpt1);
      end
      rst_n = 1'b1;
      chk("t6_no_release", 32'(cnt_a), 32'd0);
      chk("t6_norpt_repeats", 32'(cnt_b), 32'd0);
      btn = 2'b00;
      run(12);

      // random segments with rare resets
      for (int seg = 0; seg < 60; seg++) begin
         btn = 2'($urandom_range(0, 3));
         len = int'($urandom_range(1, 14));
         for (int j = 0; j < len; j++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step();
         end
         rst_n = 1'b1;
      end
      btn = 2'b00;
      run(12);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
